// File: rtl/csr_seed_pool_if.sv
// Bundle of noise-source and CSR-access signals for the Zkr seed CSR.
// master drives samples and accesses; slave is the seed pool.
interface csr_seed_pool_if #(
  parameter int XLEN = 32
);
  logic            RawValid;
  logic [15:0]     RawSample;
  logic [11:0]     CSRAdrM;
  logic            CSRReadM;
  logic            CSRWriteM;
  logic            StallM;
  logic            FlushM;
  logic [1:0]      PrivilegeModeM;
  logic            SSEED;
  logic            USEED;
  logic [XLEN-1:0] SeedReadValM;
  logic            IllegalSeedAccessM;
  logic            SeedDead;

  modport master (
    output RawValid, RawSample, CSRAdrM, CSRReadM, CSRWriteM, StallM, FlushM,
           PrivilegeModeM, SSEED, USEED,
    input  SeedReadValM, IllegalSeedAccessM, SeedDead
  );

  modport slave (
    input  RawValid, RawSample, CSRAdrM, CSRReadM, CSRWriteM, StallM, FlushM,
           PrivilegeModeM, SSEED, USEED,
    output SeedReadValM, IllegalSeedAccessM, SeedDead
  );
endinterface

// File: rtl/csr_seed_pool.sv
// Zkr seed CSR (0x015): repetition-count health test, entropy FIFO and OPST status.
// Define SEED_ADAPTIVE_PROPORTION_EN to add the adaptive-proportion health test.
module csr_seed_pool #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 8,
  parameter int BIST_CYCLES = 64,
  parameter int RCT_CUTOFF  = 6
) (
  input logic            clk,
  input logic            reset,
  csr_seed_pool_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BIST_CYCLES + 1);
  localparam logic [BW-1:0] BIST_LAST = BW'(BIST_CYCLES - 1);
  localparam logic [BW-1:0] BIST_ONE  = BW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [7:0]    RCT_LIMIT = 8'(RCT_CUTOFF);
  localparam logic [11:0]   SEED_ADR  = 12'h015;

  typedef enum logic [1:0] {
    ST_BIST = 2'b00,
    ST_WAIT = 2'b01,
    ST_ES16 = 2'b10,
    ST_DEAD = 2'b11
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_bist_cnt;
  logic [7:0]      r_rct_cnt, w_rct_nxt;
  logic [15:0]     r_last;
  logic [15:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic            w_test_en, w_rct_fail, w_apt_fail, w_fail;
  logic            w_adr_hit, w_priv_ok, w_legal, w_push, w_pop;
  logic [15:0]     w_entropy;
  logic [XLEN-1:0] w_rd_val;

  assign w_test_en  = bus.RawValid && (r_state != ST_DEAD);
  // A zero run length marks "no sample since reset", so the first sample counts as 1.
  assign w_rct_nxt  = ((r_rct_cnt != 8'd0) && (bus.RawSample == r_last)) ? (r_rct_cnt + 8'd1) : 8'd1;
  assign w_rct_fail = w_test_en && (w_rct_nxt == RCT_LIMIT);
  assign w_fail     = w_rct_fail || w_apt_fail;

`ifdef SEED_ADAPTIVE_PROPORTION_EN
  logic [5:0]  r_apt_win, r_apt_cnt, w_apt_cnt_nxt;
  logic [15:0] r_apt_ref;

  // Match count within the current 64-sample window; the window's first sample is the reference.
  always_comb begin
    w_apt_cnt_nxt = r_apt_cnt;
    if (r_apt_win == 6'd0) begin
      w_apt_cnt_nxt = 6'd1;
    end else if (bus.RawSample == r_apt_ref) begin
      w_apt_cnt_nxt = r_apt_cnt + 6'd1;
    end else begin
      w_apt_cnt_nxt = r_apt_cnt;
    end
  end

  assign w_apt_fail = w_test_en && (w_apt_cnt_nxt == 6'd40);

  // Adaptive-proportion window position, reference and match count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_apt_win <= 6'd0;
      r_apt_cnt <= 6'd0;
      r_apt_ref <= 16'h0000;
    end else if (w_test_en) begin
      r_apt_win <= r_apt_win + 6'd1;
      r_apt_cnt <= w_apt_cnt_nxt;
      if (r_apt_win == 6'd0) begin
        r_apt_ref <= bus.RawSample;
      end
    end
  end
`else
  assign w_apt_fail = 1'b0;
`endif

  // Privilege and write-form gating of the seed access.
  always_comb begin
    w_priv_ok = 1'b0;
    case (bus.PrivilegeModeM)
      2'b11:   w_priv_ok = 1'b1;
      2'b01:   w_priv_ok = bus.SSEED;
      2'b00:   w_priv_ok = bus.USEED;
      default: w_priv_ok = 1'b0;
    endcase
  end

  assign w_adr_hit = (bus.CSRAdrM == SEED_ADR);
  assign w_legal   = w_adr_hit && bus.CSRWriteM && w_priv_ok;
  assign w_pop     = w_legal && bus.CSRReadM && (r_state == ST_ES16) && !bus.StallM && !bus.FlushM
                     && (r_count != CNT_ZERO);
  // A full FIFO still accepts a push when the same cycle pops.
  assign w_push    = w_test_en && !w_fail && ((r_count != CNT_FULL) || w_pop);

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // OPST next state; ES16 leaves as soon as the FIFO is about to be empty.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BIST: begin
        if (r_bist_cnt == BIST_LAST) w_state_nxt = ST_WAIT;
        else                         w_state_nxt = ST_BIST;
      end
      ST_WAIT: begin
        if (r_count != CNT_ZERO) w_state_nxt = ST_ES16;
        else                     w_state_nxt = ST_WAIT;
      end
      ST_ES16: begin
        if (w_count_nxt == CNT_ZERO) w_state_nxt = ST_WAIT;
        else                         w_state_nxt = ST_ES16;
      end
      ST_DEAD: w_state_nxt = ST_DEAD;
      default: w_state_nxt = ST_BIST;
    endcase
    if (w_fail) begin
      w_state_nxt = ST_DEAD;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State, BIST timer, health-test history and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_BIST;
      r_bist_cnt <= {BW{1'b0}};
      r_rct_cnt  <= 8'd0;
      r_last     <= 16'h0000;
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_count    <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (r_state == ST_BIST) r_bist_cnt <= r_bist_cnt + BIST_ONE;
      if (w_test_en) begin
        r_rct_cnt <= w_rct_nxt;
        r_last    <= bus.RawSample;
      end
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Entropy storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.RawSample;
  end

  // Read value: OPST in [31:30], entropy only while ES16.
  always_comb begin
    w_entropy = 16'h0000;
    if (r_state == ST_ES16) w_entropy = r_mem[r_rptr];
    else                    w_entropy = 16'h0000;
    w_rd_val        = {XLEN{1'b0}};
    w_rd_val[31:0]  = {r_state, 14'b0, w_entropy};
  end

  assign bus.SeedReadValM       = w_legal ? w_rd_val : {XLEN{1'b0}};
  assign bus.IllegalSeedAccessM = !w_legal;
  assign bus.SeedDead           = (r_state == ST_DEAD);
endmodule

// File: tb/tb_csr_seed_pool.sv
// Scoreboard bench for csr_seed_pool: expected {illegal, value} pushed at drive time, popped at sample time.
module tb_csr_seed_pool;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  typedef struct {
    string       tag;
    logic [32:0] exp;
  } exp_t;
  exp_t exp_q[$];

  csr_seed_pool_if #(.XLEN(32)) bus ();

  csr_seed_pool #(
    .XLEN(32), .DEPTH(8), .BIST_CYCLES(64), .RCT_CUTOFF(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_expect(input string tag, input logic [32:0] exp);
    exp_q.push_back('{tag, exp});
  endtask

  task automatic sb_compare(input logic [32:0] got);
    exp_t e;
    e = exp_q.pop_front();
    check_eq(e.tag, got, e.exp);
  endtask

  task automatic raw(input logic [15:0] s);
    @(negedge clk);
    bus.CSRReadM  = 1'b0;
    bus.RawValid  = 1'b1;
    bus.RawSample = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.RawValid = 1'b0;
      bus.CSRReadM = 1'b0;
    end
  endtask

  // One access; held for stalls+1 cycles, expected {illegal, value} on every cycle.
  task automatic csr_access(input string tag, input logic [1:0] mode, input logic wr,
                            input logic [11:0] adr, input int stalls, input logic flush,
                            input logic [32:0] exp);
    @(negedge clk);
    bus.RawValid       = 1'b0;
    bus.CSRReadM       = 1'b1;
    bus.CSRWriteM      = wr;
    bus.CSRAdrM        = adr;
    bus.PrivilegeModeM = mode;
    bus.FlushM         = flush;
    for (int i = 0; i <= stalls; i++) begin
      bus.StallM = (i < stalls);
      sb_expect(tag, exp);
      #1;
      sb_compare({bus.IllegalSeedAccessM, bus.SeedReadValM});
      if (i < stalls) @(negedge clk);
    end
    @(negedge clk);
    bus.CSRReadM  = 1'b0;
    bus.CSRWriteM = 1'b0;
    bus.StallM    = 1'b0;
    bus.FlushM    = 1'b0;
  endtask

  task automatic expect_dead(input string tag, input logic d);
    sb_expect(tag, {32'h0, d});
    #1;
    sb_compare({32'h0, bus.SeedDead});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.RawValid = 1'b0;  bus.RawSample = 16'h0;  bus.CSRAdrM = 12'h0;
    bus.CSRReadM = 1'b0;  bus.CSRWriteM = 1'b0;   bus.StallM = 1'b0;
    bus.FlushM = 1'b0;    bus.PrivilegeModeM = 2'b11;
    bus.SSEED = 1'b0;     bus.USEED = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_dead("reset_dead", 1'b0);

    repeat (27) @(negedge clk);
    csr_access("bist_read", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h0000_0000});
    repeat (40) @(negedge clk);
    csr_access("wait_read", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h4000_0000});

    raw(16'h1234); raw(16'hABCD); idle(2);
    csr_access("es16_rd1", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h8000_1234});
    csr_access("es16_rd2", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h8000_ABCD});
    csr_access("drain_wait", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h4000_0000});

    raw(16'h0101); raw(16'h0202); idle(2);
    csr_access("csrrs_x0", 2'b11, 1'b0, 12'h015, 0, 1'b0, {1'b1, 32'h0});
    csr_access("s_nosseed", 2'b01, 1'b1, 12'h015, 0, 1'b0, {1'b1, 32'h0});
    csr_access("u_nouseed", 2'b00, 1'b1, 12'h015, 0, 1'b0, {1'b1, 32'h0});
    csr_access("other_adr", 2'b11, 1'b1, 12'h300, 0, 1'b0, {1'b1, 32'h0});
    bus.SSEED = 1'b1;
    csr_access("s_sseed", 2'b01, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h8000_0101});
    csr_access("m_after_s", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h8000_0202});

    for (int v = 1; v <= 9; v++) raw(16'(v));
    idle(2);
    for (int v = 1; v <= 8; v++)
      csr_access($sformatf("fill_rd%0d", v), 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h8000_0000 | 32'(v)});
    csr_access("overflow_drop", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h4000_0000});

    raw(16'h00AA); raw(16'h00BB); idle(2);
    csr_access("stall_hold", 2'b11, 1'b1, 12'h015, 3, 1'b0, {1'b0, 32'h8000_00AA});
    csr_access("after_stall", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h8000_00BB});

    raw(16'h00CC); idle(2);
    csr_access("flush_nopop", 2'b11, 1'b1, 12'h015, 0, 1'b1, {1'b0, 32'h8000_00CC});
    csr_access("after_flush", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h8000_00CC});

    for (int k = 0; k < 6; k++) raw(16'h5555);
    expect_dead("rct_not_yet", 1'b0);
    idle(1);
    expect_dead("rct_dead", 1'b1);
    raw(16'h1111); idle(1);
    csr_access("dead_read", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'hC000_0000});

    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    expect_dead("rst_clears_dead", 1'b0);
    csr_access("rst_bist", 2'b11, 1'b1, 12'h015, 0, 1'b0, {1'b0, 32'h0000_0000});

    check_eq("sb_drain", 33'(exp_q.size()), 33'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
